// File: rtl/link_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : link_tx_scheduler_pkg
// Purpose  : Shared definitions for the link transmit scheduler: symbol width,
//            the comma/idle symbol and the scheduler state encoding.
// Contents : SYM_W, COMMA, state_t (ST_TRAIN / ST_ACTIVE)
// Revision : 1.0 - initial release
// ============================================================================
package link_tx_scheduler_pkg;

    localparam int SYM_W = 8;

    // Idle and training symbol, also used by the far end for symbol lock.
    localparam logic [SYM_W-1:0] COMMA = 8'hBC;

    typedef enum logic [0:0] {
        ST_TRAIN  = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage : link_tx_scheduler_pkg
`default_nettype wire

// File: rtl/link_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : link_tx_scheduler_if
// Purpose  : Bundles the lane request side and the serializer side of the
//            link transmit scheduler.
// Signals  : req, lane_data        lanes      -> scheduler
//            grant                 scheduler  -> lanes
//            sym_out, sym_valid,   scheduler  -> serializer
//            sym_load
//            link_up, comma_err    scheduler  -> status
// Modports : master = lanes/serializer environment, slave = scheduler
// Revision : 1.0 - initial release
// ============================================================================
interface link_tx_scheduler_if
    import link_tx_scheduler_pkg::*;
#(
    parameter int N_LANES = 4
) ();

    logic [N_LANES-1:0]       req;
    logic [SYM_W*N_LANES-1:0] lane_data;
    logic [N_LANES-1:0]       grant;
    logic [SYM_W-1:0]         sym_out;
    logic                     sym_valid;
    logic                     sym_load;
    logic                     link_up;
    logic                     comma_err;

    modport master (
        output req, lane_data,
        input  grant, sym_out, sym_valid, sym_load, link_up, comma_err
    );

    modport slave (
        input  req, lane_data,
        output grant, sym_out, sym_valid, sym_load, link_up, comma_err
    );

endinterface : link_tx_scheduler_if
`default_nettype wire

// File: rtl/link_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : link_tx_scheduler_rr_arbiter
// Purpose  : Combinational round-robin pick: the first set request at or
//            after ptr, searching upward and wrapping modulo N_LANES.
// Ports    : req        in   N_LANES   request vector
//            ptr        in   PTR_W     search start lane (always < N_LANES)
//            winner_oh  out  N_LANES   one-hot winner (0 when no request)
//            winner_idx out  PTR_W     winner index (0 when no request)
//            any        out  1         at least one request set
// Revision : 1.0 - initial release
// ============================================================================
module link_tx_scheduler_rr_arbiter #(
    parameter int N_LANES = 4,
    parameter int PTR_W   = $clog2(N_LANES)
) (
    input  wire logic [N_LANES-1:0] req,
    input  wire logic [PTR_W-1:0]   ptr,
    output logic      [N_LANES-1:0] winner_oh,
    output logic      [PTR_W-1:0]   winner_idx,
    output logic                    any
);

    int w_lane;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        any        = 1'b0;
        w_lane     = 0;
        for (int k = 0; k < N_LANES; k++) begin
            // ptr never exceeds N_LANES-1, so one wrap step is enough.
            w_lane = int'(ptr) + k;
            if (w_lane >= N_LANES) begin
                w_lane = w_lane - N_LANES;
            end
            if (!any && req[w_lane]) begin
                any               = 1'b1;
                winner_oh[w_lane] = 1'b1;
                winner_idx        = PTR_W'(w_lane);
            end
        end
    end

endmodule : link_tx_scheduler_rr_arbiter
`default_nettype wire

// File: rtl/link_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : link_tx_scheduler
// Purpose  : Transmit-side scheduler for the 8-bit serial link. Divides the
//            link into SYM_CYCLES-cycle symbol slots, sends TRAIN_SYMS commas
//            for far-end lock, then shares slots round-robin among N_LANES
//            requesters, filling empty slots with comma idles.
// Ports    : clk8     in   1   link clock
//            reset8   in   1   asynchronous active-low reset
//            retrain  in   1   pulse: re-run training at next slot boundary
//            bus      slave    req/lane_data in; grant, sym_out, sym_valid,
//                              sym_load, link_up, comma_err out
// Revision : 1.0 - initial release
// ============================================================================
module link_tx_scheduler
    import link_tx_scheduler_pkg::*;
#(
    parameter int N_LANES    = 4,
    parameter int SYM_CYCLES = 8,
    parameter int TRAIN_SYMS = 8
) (
    input  wire logic           clk8,
    input  wire logic           reset8,
    input  wire logic           retrain,
    link_tx_scheduler_if.slave  bus
);

    localparam int SC_W  = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
    localparam int TC_W  = $clog2(TRAIN_SYMS + 1);
    localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    localparam logic [SC_W-1:0]  SLOT_LAST  = SC_W'(SYM_CYCLES - 1);
    localparam logic [TC_W-1:0]  TRAIN_LAST = TC_W'(TRAIN_SYMS - 1);
    localparam logic [PTR_W-1:0] LANE_LAST  = PTR_W'(N_LANES - 1);

    state_t               r_state;
    logic [SC_W-1:0]      r_slot_cnt;
    logic [TC_W-1:0]      r_train_cnt;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic                 r_retrain_pend;
    logic [SYM_W-1:0]     r_sym_out;
    logic                 r_sym_valid;
    logic                 r_sym_load;
    logic [N_LANES-1:0]   r_grant;
    logic                 r_link_up;
    logic                 r_comma_err;

    logic [N_LANES-1:0]   w_win_oh;
    logic [PTR_W-1:0]     w_win_idx;
    logic                 w_any_req;
    logic [SYM_W-1:0]     w_win_sym;
    logic [PTR_W-1:0]     w_next_ptr;
    logic                 w_boundary;
    logic                 w_retrain_now;

    link_tx_scheduler_rr_arbiter #(
        .N_LANES (N_LANES),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req        (bus.req),
        .ptr        (r_rr_ptr),
        .winner_oh  (w_win_oh),
        .winner_idx (w_win_idx),
        .any        (w_any_req)
    );

    assign w_win_sym     = bus.lane_data[int'(w_win_idx)*SYM_W +: SYM_W];
    assign w_next_ptr    = (w_win_idx == LANE_LAST) ? '0 : w_win_idx + 1'b1;
    assign w_boundary    = (r_slot_cnt == SLOT_LAST);
    // A pulse landing exactly on the boundary edge is acted on immediately.
    assign w_retrain_now = r_retrain_pend | retrain;

    always_ff @(posedge clk8 or negedge reset8) begin
        if (!reset8) begin
            r_state        <= ST_TRAIN;
            r_slot_cnt     <= '0;
            r_train_cnt    <= '0;
            r_rr_ptr       <= '0;
            r_retrain_pend <= 1'b0;
            r_sym_out      <= COMMA;
            r_sym_valid    <= 1'b0;
            r_sym_load     <= 1'b0;
            r_grant        <= '0;
            r_link_up      <= 1'b0;
            r_comma_err    <= 1'b0;
        end else begin
            // Strobes live for exactly the cycle after a boundary.
            r_sym_load  <= 1'b0;
            r_grant     <= '0;
            r_comma_err <= 1'b0;

            if (retrain) begin
                r_retrain_pend <= 1'b1;
            end

            if (!w_boundary) begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end else begin
                r_slot_cnt     <= '0;
                r_sym_load     <= 1'b1;
                r_retrain_pend <= 1'b0;

                case (r_state)
                    ST_TRAIN: begin
                        r_sym_out   <= COMMA;
                        r_sym_valid <= 1'b0;
                        if (w_retrain_now) begin
                            r_train_cnt <= '0;
                        end else if (r_train_cnt == TRAIN_LAST) begin
                            r_train_cnt <= '0;
                            r_state     <= ST_ACTIVE;
                            r_link_up   <= 1'b1;
                        end else begin
                            r_train_cnt <= r_train_cnt + 1'b1;
                        end
                    end

                    ST_ACTIVE: begin
                        if (w_retrain_now) begin
                            // This slot's comma is the first training symbol.
                            r_sym_out   <= COMMA;
                            r_sym_valid <= 1'b0;
                            r_train_cnt <= TC_W'(1);
                            r_state     <= ST_TRAIN;
                            r_link_up   <= 1'b0;
                        end else if (w_any_req) begin
                            r_sym_out   <= w_win_sym;
                            r_sym_valid <= 1'b1;
                            r_grant     <= w_win_oh;
                            r_rr_ptr    <= w_next_ptr;
                            // Data aliasing the comma is still sent; the far
                            // end will drop it, so flag it upstream.
                            r_comma_err <= (w_win_sym == COMMA);
                        end else begin
                            r_sym_out   <= COMMA;
                            r_sym_valid <= 1'b0;
                        end
                    end

                    default: begin
                        r_state   <= ST_TRAIN;
                        r_link_up <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.grant     = r_grant;
    assign bus.sym_out   = r_sym_out;
    assign bus.sym_valid = r_sym_valid;
    assign bus.sym_load  = r_sym_load;
    assign bus.link_up   = r_link_up;
    assign bus.comma_err = r_comma_err;

endmodule : link_tx_scheduler
`default_nettype wire

// File: tb/tb_link_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_tx_scheduler
// Purpose  : Self-checking bench for link_tx_scheduler (N_LANES=4,
//            SYM_CYCLES=8, TRAIN_SYMS=8). Per-slot vectors are applied from a
//            table; expected symbols are queued and compared on sym_load.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_tx_scheduler;

    localparam int          C_LANES = 4;
    localparam logic [31:0] C_D0    = 32'h4433_2211;
    localparam logic [31:0] C_D5    = 32'h4433_BC11;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic        rt;
        logic [7:0]  sym;
        logic        valid;
        logic [3:0]  grant;
        logic        cerr;
        logic        lup;
    } vec_t;

    logic clk8    = 1'b0;
    logic reset8  = 1'b0;
    logic retrain = 1'b0;

    int   n_checks = 0;
    int   n_errors = 0;

    vec_t vecs[$];
    vec_t exp_q[$];

    link_tx_scheduler_if #(.N_LANES(C_LANES)) bus ();

    link_tx_scheduler #(
        .N_LANES    (C_LANES),
        .SYM_CYCLES (8),
        .TRAIN_SYMS (8)
    ) dut (
        .clk8    (clk8),
        .reset8  (reset8),
        .retrain (retrain),
        .bus     (bus)
    );

    always #5 clk8 = ~clk8;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add_vec(input logic [3:0] rq, input logic [31:0] d, input logic rt,
                                    input logic [7:0] s, input logic v, input logic [3:0] g,
                                    input logic ce, input logic lu);
        vec_t t;
        t.req = rq; t.data = d; t.rt = rt; t.sym = s;
        t.valid = v; t.grant = g; t.cerr = ce; t.lup = lu;
        vecs.push_back(t);
    endfunction

    // Scoreboard: every sym_load pops one expected symbol.
    always @(negedge clk8) begin
        if (bus.sym_load === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_load", 32'd1, 32'd0);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk("sym_out",   bus.sym_out,   e.sym);
                chk("sym_valid", bus.sym_valid, e.valid);
                chk("grant",     bus.grant,     e.grant);
                chk("comma_err", bus.comma_err, e.cerr);
                chk("link_up",   bus.link_up,   e.lup);
            end
        end else begin
            chk("idle_grant",     bus.grant,     32'd0);
            chk("idle_comma_err", bus.comma_err, 32'd0);
        end
    end

    // Called at a negedge; returns at the negedge where the slot's load shows.
    task automatic do_slot(input vec_t v);
        bus.req       = v.req;
        bus.lane_data = v.data;
        exp_q.push_back(v);
        repeat (3) @(posedge clk8);
        if (v.rt) begin
            @(negedge clk8) retrain = 1'b1;
            @(negedge clk8) retrain = 1'b0;
            repeat (4) @(posedge clk8);
        end else begin
            repeat (5) @(posedge clk8);
        end
        @(negedge clk8);
        chk("load_timing", bus.sym_load, 32'd1);
    endtask

    initial begin
        // Training from reset: 8 commas, link_up with the 8th.
        for (int i = 0; i < 7; i++) add_vec(4'b0000, C_D0, 1'b0, 8'hBC, 1'b0, 4'b0000, 1'b0, 1'b0);
        add_vec(4'b0000, C_D0, 1'b0, 8'hBC, 1'b0, 4'b0000, 1'b0, 1'b1);
        // All lanes requesting.
        add_vec(4'b1111, C_D0, 1'b0, 8'h11, 1'b1, 4'b0001, 1'b0, 1'b1);
        add_vec(4'b1111, C_D0, 1'b0, 8'h22, 1'b1, 4'b0010, 1'b0, 1'b1);
        add_vec(4'b1111, C_D0, 1'b0, 8'h33, 1'b1, 4'b0100, 1'b0, 1'b1);
        add_vec(4'b1111, C_D0, 1'b0, 8'h44, 1'b1, 4'b1000, 1'b0, 1'b1);
        add_vec(4'b1111, C_D0, 1'b0, 8'h11, 1'b1, 4'b0001, 1'b0, 1'b1);
        // Single lane 2, then no request.
        add_vec(4'b0100, C_D0, 1'b0, 8'h33, 1'b1, 4'b0100, 1'b0, 1'b1);
        add_vec(4'b0100, C_D0, 1'b0, 8'h33, 1'b1, 4'b0100, 1'b0, 1'b1);
        add_vec(4'b0000, C_D0, 1'b0, 8'hBC, 1'b0, 4'b0000, 1'b0, 1'b1);
        // Lane 1 carries a comma as data (search starts at lane 3, wraps).
        add_vec(4'b0010, C_D5, 1'b0, 8'hBC, 1'b1, 4'b0010, 1'b1, 1'b1);
        // Round-robin wrap between lanes 3 and 0.
        add_vec(4'b1001, C_D0, 1'b0, 8'h44, 1'b1, 4'b1000, 1'b0, 1'b1);
        add_vec(4'b1001, C_D0, 1'b0, 8'h11, 1'b1, 4'b0001, 1'b0, 1'b1);
        add_vec(4'b1001, C_D0, 1'b0, 8'h44, 1'b1, 4'b1000, 1'b0, 1'b1);
        // Retrain pulse mid-slot: 8 comma slots, then traffic resumes.
        add_vec(4'b1111, C_D0, 1'b1, 8'hBC, 1'b0, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) add_vec(4'b1111, C_D0, 1'b0, 8'hBC, 1'b0, 4'b0000, 1'b0, 1'b0);
        add_vec(4'b1111, C_D0, 1'b0, 8'hBC, 1'b0, 4'b0000, 1'b0, 1'b1);
        add_vec(4'b1111, C_D0, 1'b0, 8'h11, 1'b1, 4'b0001, 1'b0, 1'b1);
        add_vec(4'b1111, C_D0, 1'b0, 8'h22, 1'b1, 4'b0010, 1'b0, 1'b1);
        // Granted slot interrupted by reset.
        add_vec(4'b1111, C_D0, 1'b0, 8'h33, 1'b1, 4'b0100, 1'b0, 1'b1);
        // First slot after full retraining: pointer back at lane 0.
        add_vec(4'b1111, C_D0, 1'b0, 8'h11, 1'b1, 4'b0001, 1'b0, 1'b1);

        bus.req       = '0;
        bus.lane_data = C_D0;
        repeat (3) @(negedge clk8);
        chk("rst_sym_out",   bus.sym_out,   32'hBC);
        chk("rst_sym_valid", bus.sym_valid, 32'd0);
        chk("rst_sym_load",  bus.sym_load,  32'd0);
        chk("rst_grant",     bus.grant,     32'd0);
        chk("rst_link_up",   bus.link_up,   32'd0);
        chk("rst_comma_err", bus.comma_err, 32'd0);
        reset8 = 1'b1;

        for (int i = 0; i < vecs.size() - 1; i++) begin
            do_slot(vecs[i]);
        end

        // Grant is showing now; asynchronous reset must clear it at once.
        #2 reset8 = 1'b0;
        #1;
        chk("midrst_sym_out",   bus.sym_out,   32'hBC);
        chk("midrst_sym_valid", bus.sym_valid, 32'd0);
        chk("midrst_sym_load",  bus.sym_load,  32'd0);
        chk("midrst_grant",     bus.grant,     32'd0);
        chk("midrst_link_up",   bus.link_up,   32'd0);
        chk("midrst_comma_err", bus.comma_err, 32'd0);
        bus.req = '0;
        repeat (3) @(negedge clk8);
        reset8 = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_slot(vecs[i]);
        end
        do_slot(vecs[vecs.size() - 1]);

        @(negedge clk8);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_link_tx_scheduler
`default_nettype wire
